// File: rtl/kernel_pipe_buffer.sv
// Elastic operand buffer between operand fetch and the adder/abs-diff array.
// DEPTH-entry FIFO with valid/ready handshake plus a weight-stationary holding register.
module kernel_pipe_buffer #(
    parameter int unsigned NBIT  = 8,
    parameter int unsigned NDATA = 9,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [NBIT*NDATA-1:0]        i_if,
    input  logic [NBIT*NDATA-1:0]        i_w,
    input  logic                         i_wload,
    input  logic                         i_wstat,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [NBIT*NDATA-1:0]        o_if,
    output logic [NBIT*NDATA-1:0]        o_w,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_mode
);

    localparam int unsigned DW = NBIT * NDATA;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          mode_q, mode_d;
    logic [DW-1:0] wreg_q, wreg_d;
    logic [DW-1:0] if_mem_q [DEPTH];
    logic [DW-1:0] if_mem_d [DEPTH];
    logic [DW-1:0] w_mem_q  [DEPTH];
    logic [DW-1:0] w_mem_d  [DEPTH];

    logic empty;
    logic full;
    logic push;
    logic pop;

    // Reload and mode change wait for an empty buffer so no queued beat sees them.
    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == CW'(DEPTH));
        o_ready = !full
                  && !(i_wstat && i_wload && !empty)
                  && !((i_wstat != mode_q) && !empty);
        push    = i_valid && o_ready;
        pop     = !empty && i_ready;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mode_d   = mode_q;
        wreg_d   = wreg_q;
        if_mem_d = if_mem_q;
        w_mem_d  = w_mem_q;

        if (push) begin
            if_mem_d[wr_ptr_q] = i_if;
            if (!i_wstat) begin
                w_mem_d[wr_ptr_q] = i_w;
            end
            if (i_wstat && i_wload) begin
                wreg_d = i_w;
            end
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        // Mode follows the request whenever the buffer is idle or a beat is accepted.
        if (push || empty) begin
            mode_d = i_wstat;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            mode_q   <= 1'b0;
            wreg_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mode_q   <= mode_d;
            wreg_q   <= wreg_d;
        end
    end

    // Storage needs no reset: outputs are masked while the buffer is empty.
    always_ff @(posedge CLK) begin
        if_mem_q <= if_mem_d;
        w_mem_q  <= w_mem_d;
    end

    always_comb begin
        o_valid = !empty;
        o_count = count_q;
        o_mode  = mode_q;
        o_if    = empty ? '0 : if_mem_q[rd_ptr_q];
        o_w     = mode_q ? wreg_q : (empty ? '0 : w_mem_q[rd_ptr_q]);
    end

endmodule

// File: tb/tb_kernel_pipe_buffer.sv
// Scoreboard bench for kernel_pipe_buffer: a queue-based model predicts handshake,
// occupancy, mode and the head beat; a separate monitor compares the head every cycle.
module tb_kernel_pipe_buffer;

    localparam int unsigned NBIT  = 8;
    localparam int unsigned NDATA = 9;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned DW    = NBIT * NDATA;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    typedef struct {
        logic [DW-1:0] ifv;
        logic [DW-1:0] w;
    } exp_t;

    logic          CLK;
    logic          RST;
    logic          i_valid;
    logic          o_ready;
    logic [DW-1:0] i_if;
    logic [DW-1:0] i_w;
    logic          i_wload;
    logic          i_wstat;
    logic          o_valid;
    logic          i_ready;
    logic [DW-1:0] o_if;
    logic [DW-1:0] o_w;
    logic [CW-1:0] o_count;
    logic          o_mode;

    kernel_pipe_buffer #(.NBIT(NBIT), .NDATA(NDATA), .DEPTH(DEPTH)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_if    (i_if),
        .i_w     (i_w),
        .i_wload (i_wload),
        .i_wstat (i_wstat),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_if    (o_if),
        .o_w     (o_w),
        .o_count (o_count),
        .o_mode  (o_mode)
    );

    int            n_tests = 0;
    int            n_fail  = 0;
    exp_t          sb[$];
    int            m_count = 0;
    logic          m_mode  = 1'b0;
    logic [DW-1:0] m_wreg  = '0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] lanes(input int b);
        logic [DW-1:0] v;
        for (int k = 0; k < int'(NDATA); k++) v[k*NBIT +: NBIT] = NBIT'(b * 16 + k);
        return v;
    endfunction

    function automatic logic [DW-1:0] rnd();
        return DW'({$urandom, $urandom, $urandom});
    endfunction

    // One cycle: drive, check handshake/occupancy against the model, then advance the model.
    task automatic step(input logic v, input logic [DW-1:0] fi, input logic [DW-1:0] wi,
                        input logic wl, input logic ws, input logic rd, output logic acc);
        logic exp_rdy;
        logic push;
        logic pop;
        exp_t e;
        int   old_count;
        @(negedge CLK);
        RST = 1'b0; i_valid = v; i_if = fi; i_w = wi; i_wload = wl; i_wstat = ws; i_ready = rd;
        #1;
        exp_rdy = (m_count != int'(DEPTH)) && !(ws && wl && m_count != 0)
                  && !((ws != m_mode) && m_count != 0);
        chk("o_ready", DW'(o_ready), DW'(exp_rdy));
        chk("o_count", DW'(o_count), DW'(m_count));
        chk("o_mode",  DW'(o_mode),  DW'(m_mode));
        chk("o_valid", DW'(o_valid), DW'(m_count != 0));
        push = v && exp_rdy;
        pop  = (m_count != 0) && rd;
        if (push) begin
            e.ifv = fi;
            e.w   = ws ? (wl ? wi : m_wreg) : wi;
            sb.push_back(e);
        end
        @(posedge CLK);
        old_count = m_count;
        m_count   = m_count + int'(push) - int'(pop);
        if (push || old_count == 0) m_mode = ws;
        if (push && ws && wl) m_wreg = wi;
        acc = push;
    endtask

    task automatic send(input logic [DW-1:0] fi, input logic [DW-1:0] wi,
                        input logic wl, input logic ws, input logic rd);
        logic a;
        int   n = 0;
        do begin
            step(1'b1, fi, wi, wl, ws, rd, a);
            n++;
        end while (!a && n < 64);
        if (!a) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: beat not accepted within %0d cycles", n);
        end
    endtask

    task automatic idle(input int n, input logic rd, input logic ws);
        logic a;
        for (int i = 0; i < n; i++) step(1'b0, rnd(), rnd(), 1'b0, ws, rd, a);
    endtask

    task automatic do_reset(input logic v, input logic rd);
        @(negedge CLK);
        RST = 1'b1; i_valid = v; i_ready = rd; i_wload = 1'b0; i_wstat = 1'b0;
        i_if = rnd(); i_w = rnd();
        @(posedge CLK);
        m_count = 0;
        m_mode  = 1'b0;
        m_wreg  = '0;
        sb.delete();
    endtask

    // Monitor: compares the head against the scoreboard whenever the DUT presents it.
    initial begin
        forever begin
            @(negedge CLK);
            #2;
            if (!RST) begin
                if (o_valid) begin
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL sb_underflow: o_valid=1 with no expected beat, o_if=%h", o_if);
                    end else begin
                        chk("o_if", o_if, sb[0].ifv);
                        chk("o_w",  o_w,  sb[0].w);
                        if (i_ready) void'(sb.pop_front());
                    end
                end else begin
                    chk("o_if_idle", o_if, '0);
                    chk("o_w_idle",  o_w,  m_mode ? m_wreg : '0);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic a;
        int   b;
        logic ws;
        RST = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_wload = 1'b0; i_wstat = 1'b0;
        i_if = '0; i_w = '0;
        do_reset(1'b0, 1'b0);

        // Streaming, in-order, single-cycle latency
        for (int i = 0; i < 3; i++) send(lanes(i), ~lanes(i), 1'b0, 1'b0, 1'b1);
        idle(3, 1'b1, 1'b0);

        // Fill with back-pressure, then drain
        b = 4;
        for (int c = 0; c < int'(DEPTH) + 2; c++) begin
            step(1'b1, lanes(b), ~lanes(b), 1'b0, 1'b0, 1'b0, a);
            if (a) b++;
        end
        idle(2, 1'b0, 1'b0);
        send(lanes(b), ~lanes(b), 1'b0, 1'b0, 1'b1);
        send(lanes(b + 1), ~lanes(b + 1), 1'b0, 1'b0, 1'b1);
        idle(DEPTH + 2, 1'b1, 1'b0);

        // Weight-stationary with reload stalled behind buffered entries
        send(rnd(), {NDATA{8'h05}}, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) send(rnd(), rnd(), 1'b0, 1'b1, 1'b1);
        idle(3, 1'b1, 1'b1);
        send(rnd(), rnd(), 1'b0, 1'b1, 1'b0);
        send(rnd(), rnd(), 1'b0, 1'b1, 1'b0);
        step(1'b1, rnd(), {NDATA{8'h0A}}, 1'b1, 1'b1, 1'b0, a);
        step(1'b1, rnd(), {NDATA{8'h0A}}, 1'b1, 1'b1, 1'b0, a);
        send(rnd(), {NDATA{8'h0A}}, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) send(rnd(), rnd(), 1'b0, 1'b1, 1'b1);
        idle(4, 1'b1, 1'b1);

        // Mode change requested with entries buffered
        idle(2, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) send(rnd(), rnd(), 1'b0, 1'b0, 1'b0);
        step(1'b1, rnd(), rnd(), 1'b0, 1'b1, 1'b0, a);
        step(1'b1, rnd(), rnd(), 1'b0, 1'b1, 1'b0, a);
        send(rnd(), rnd(), 1'b0, 1'b1, 1'b1);
        idle(4, 1'b1, 1'b1);

        // Pointer wrap under random back-pressure
        idle(2, 1'b1, 1'b0);
        for (int i = 0; i < 3 * int'(DEPTH) + 1; i++) begin
            send(rnd(), rnd(), 1'b0, 1'b0, 1'($urandom_range(0, 1)));
        end
        idle(DEPTH + 4, 1'b1, 1'b0);

        // Mixed random traffic including reloads and mode flips
        ws = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) ws = ~ws;
            step(1'($urandom_range(0, 3) != 0), rnd(), rnd(), 1'($urandom_range(0, 5) == 0),
                 ws, 1'($urandom_range(0, 2) != 0), a);
        end
        idle(DEPTH + 4, 1'b1, 1'b0);

        // Reset while busy
        for (int i = 0; i < 3; i++) send(rnd(), rnd(), 1'b0, 1'b0, 1'b0);
        do_reset(1'b1, 1'b1);
        idle(3, 1'b1, 1'b0);

        chk("sb_empty", DW'(sb.size()), '0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
